// File: rtl/i2s_dac_tx.sv
// rtl/i2s_dac_tx.sv - I2S DAC transmitter with one-pair holding buffer; define I2S_TX_UNDERRUN_CNT_EN for underrun_count
module i2s_dac_tx #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_DACLRCK,
  output logic                  AUD_DACDAT,
  input  logic [DATA_WIDTH-1:0] s_left,
  input  logic [DATA_WIDTH-1:0] s_right,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]           underrun_count
`endif
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  logic bclk_s1_q, bclk_s2_q, bclk_d1_q;
  logic lrck_s1_q, lrck_s2_q;
  logic bclk_rise, bclk_fall;

  // Bring the codec clocks into the clk domain; the third BCLK flop provides edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_s1_q <= 1'b0;
      bclk_s2_q <= 1'b0;
      bclk_d1_q <= 1'b0;
      lrck_s1_q <= 1'b0;
      lrck_s2_q <= 1'b0;
    end else begin
      bclk_s1_q <= AUD_BCLK;
      bclk_s2_q <= bclk_s1_q;
      bclk_d1_q <= bclk_s2_q;
      lrck_s1_q <= AUD_DACLRCK;
      lrck_s2_q <= lrck_s1_q;
    end
  end

  assign bclk_rise = bclk_s2_q & ~bclk_d1_q;
  assign bclk_fall = ~bclk_s2_q & bclk_d1_q;

  state_t                  state_q, state_d;
  logic                    lr_q, lr_d;
  logic                    start_left_q, start_left_d;
  logic                    start_right_q, start_right_d;
  logic                    buf_full_q, buf_full_d;
  logic [DATA_WIDTH-1:0]   buf_left_q, buf_left_d;
  logic [DATA_WIDTH-1:0]   buf_right_q, buf_right_d;
  logic [DATA_WIDTH-1:0]   right_hold_q, right_hold_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic                    dacdat_q, dacdat_d;
  logic                    underrun_q, underrun_d;

  logic                    xfer;
  logic                    load_left;
  logic                    load_right;
  logic [DATA_WIDTH-1:0]   load_word;

  assign s_ready    = ~buf_full_q & ~reset;
  assign xfer       = s_valid & s_ready;
  assign load_left  = bclk_fall & start_left_q;
  assign load_right = bclk_fall & start_right_q & (state_q != ST_IDLE);

  // Next-state: LRCK edge arming, channel loads, serial shifting and the holding buffer
  always_comb begin
    state_d       = state_q;
    lr_d          = lr_q;
    start_left_d  = start_left_q;
    start_right_d = start_right_q;
    buf_full_d    = buf_full_q;
    buf_left_d    = buf_left_q;
    buf_right_d   = buf_right_q;
    right_hold_d  = right_hold_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    dacdat_d      = dacdat_q;
    underrun_d    = 1'b0;
    load_word     = '0;

    if (bclk_rise) begin
      lr_d = lrck_s2_q;
      if (lrck_s2_q != lr_q) begin
        start_left_d  = ~lrck_s2_q;
        start_right_d = lrck_s2_q;
      end
    end

    // A pending start is consumed by the next falling edge whether or not it loads
    if (bclk_fall) begin
      start_left_d  = 1'b0;
      start_right_d = 1'b0;
    end

    if (load_left) begin
      state_d = ST_LEFT;
      if (buf_full_q) begin
        load_word    = buf_left_q;
        right_hold_d = buf_right_q;
        buf_full_d   = 1'b0;
      end else begin
        right_hold_d = '0;
        underrun_d   = 1'b1;
      end
    end else if (load_right) begin
      state_d   = ST_RIGHT;
      load_word = right_hold_q;
    end

    // The load edge itself drives the MSB, so the shifter keeps only the remaining bits
    if (load_left || load_right) begin
      dacdat_d  = load_word[DATA_WIDTH-1];
      shreg_d   = {load_word[DATA_WIDTH-2:0], 1'b0};
      bit_cnt_d = CNT_W'(1);
    end else if (bclk_fall && (state_q != ST_IDLE)) begin
      if (bit_cnt_q < CNT_W'(DATA_WIDTH)) begin
        dacdat_d  = shreg_q[DATA_WIDTH-1];
        shreg_d   = {shreg_q[DATA_WIDTH-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end else begin
        dacdat_d = 1'b0;
      end
    end

    // s_ready is only high while empty, so an accept never overwrites an unsent pair
    if (xfer) begin
      buf_left_d  = s_left;
      buf_right_d = s_right;
      buf_full_d  = 1'b1;
    end
  end

  // Channel FSM and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      lr_q          <= 1'b0;
      start_left_q  <= 1'b0;
      start_right_q <= 1'b0;
      buf_full_q    <= 1'b0;
      buf_left_q    <= '0;
      buf_right_q   <= '0;
      right_hold_q  <= '0;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      dacdat_q      <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      lr_q          <= lr_d;
      start_left_q  <= start_left_d;
      start_right_q <= start_right_d;
      buf_full_q    <= buf_full_d;
      buf_left_q    <= buf_left_d;
      buf_right_q   <= buf_right_d;
      right_hold_q  <= right_hold_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      dacdat_q      <= dacdat_d;
      underrun_q    <= underrun_d;
    end
  end

  assign AUD_DACDAT = dacdat_q;
  assign underrun   = underrun_q;

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] ur_cnt_q, ur_cnt_d;

  // Saturating count of frames that started with an empty buffer
  always_comb begin
    ur_cnt_d = ur_cnt_q;
    if (underrun_d && (ur_cnt_q != 16'hFFFF)) begin
      ur_cnt_d = ur_cnt_q + 16'd1;
    end
  end

  // Underrun counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      ur_cnt_q <= 16'd0;
    end else begin
      ur_cnt_q <= ur_cnt_d;
    end
  end

  assign underrun_count = ur_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb/tb_i2s_dac_tx.sv - directed self-checking bench for i2s_dac_tx
`timescale 1ns/1ps
module tb_i2s_dac_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        AUD_BCLK = 1'b1;
  logic        AUD_DACLRCK = 1'b1;
  logic        AUD_DACDAT;
  logic [31:0] s_left = '0;
  logic [31:0] s_right = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_count;
`endif

  int errors = 0;
  int checks = 0;
  logic cap [0:4095];
  int ncap = 0;
  int ur_seen = 0;
  int xfer_seen = 0;

  i2s_dac_tx #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_DACLRCK (AUD_DACLRCK),
    .AUD_DACDAT  (AUD_DACDAT),
    .s_left      (s_left),
    .s_right     (s_right),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .underrun    (underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    .underrun_count (underrun_count)
`endif
  );

  always #5 clk = ~clk;

  // Count underrun pulses and accepted transfers mid-cycle
  always @(negedge clk) begin
    if (underrun === 1'b1) ur_seen++;
    if (s_valid === 1'b1 && s_ready === 1'b1 && reset === 1'b0) xfer_seen++;
  end

  // One BCLK period: fall (with LRCK update), then rise where the DAC samples data
  task automatic tick(input logic lr);
    AUD_BCLK = 1'b0;
    AUD_DACLRCK = lr;
    #40;
    AUD_BCLK = 1'b1;
    cap[ncap] = AUD_DACDAT;
    ncap++;
    #40;
  endtask

  task automatic run_frame(input int bpc, output int start);
    start = ncap;
    for (int i = 0; i < bpc; i++) tick(1'b0);
    for (int i = 0; i < bpc; i++) tick(1'b1);
  endtask

  function automatic logic [31:0] word_at(input int idx, input int nb);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < nb; i++) w = {w[30:0], cap[idx + i]};
    return w;
  endfunction

  task automatic push(input logic [31:0] l, input logic [31:0] r);
    s_left = l;
    s_right = r;
    s_valid = 1'b1;
    #10;
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(1'b1);
    tick(1'b1);
    checks++; if (AUD_DACDAT !== 1'b0) begin errors++; $display("FAIL reset_dacdat: got %b expected 0", AUD_DACDAT); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b expected 0", s_ready); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
`ifdef I2S_TX_UNDERRUN_CNT_EN
    checks++; if (underrun_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", underrun_count); end
`endif
    reset = 1'b0;
    #10;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL post_reset_s_ready: got %b expected 1", s_ready); end
    tick(1'b1);
    tick(1'b1);
  endtask

  task automatic test_underrun();
    int st;
    int u0;
    for (int f = 0; f < 3; f++) begin
      u0 = ur_seen;
      run_frame(32, st);
      tick(1'b1);
      checks++; if (ur_seen - u0 !== 1) begin errors++; $display("FAIL underrun_pulses frame %0d: got %0d expected 1", f, ur_seen - u0); end
      checks++; if (word_at(st + 1, 32) !== 32'h0) begin errors++; $display("FAIL underrun_left frame %0d: got %h expected 0", f, word_at(st + 1, 32)); end
      checks++; if (word_at(st + 33, 32) !== 32'h0) begin errors++; $display("FAIL underrun_right frame %0d: got %h expected 0", f, word_at(st + 33, 32)); end
`ifdef I2S_TX_UNDERRUN_CNT_EN
      checks++; if (underrun_count !== 16'(f + 1)) begin errors++; $display("FAIL underrun_count frame %0d: got %0d expected %0d", f, underrun_count, f + 1); end
`endif
    end
  endtask

  task automatic test_basic();
    int st;
    int u0;
    u0 = ur_seen;
    push(32'hA5A5_0001, 32'h8000_00FF);
    run_frame(32, st);
    tick(1'b1);
    checks++; if (word_at(st + 1, 32) !== 32'hA5A5_0001) begin errors++; $display("FAIL basic_left: got %h expected a5a50001", word_at(st + 1, 32)); end
    checks++; if (word_at(st + 33, 32) !== 32'h8000_00FF) begin errors++; $display("FAIL basic_right: got %h expected 800000ff", word_at(st + 33, 32)); end
    checks++; if (ur_seen - u0 !== 0) begin errors++; $display("FAIL basic_underrun: got %0d pulses expected 0", ur_seen - u0); end
  endtask

  task automatic test_back_to_back();
    int st [4];
    int u0;
    int x0;
    u0 = ur_seen;
    x0 = xfer_seen;
    s_left = 32'h1357_9BDF;
    s_right = 32'h2468_ACE0;
    s_valid = 1'b1;
    #10;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_drop: got %b expected 0", s_ready); end
    for (int f = 0; f < 3; f++) begin
      run_frame(32, st[f]);
      if (f == 1) begin
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_mid: got %b expected 0", s_ready); end
      end
    end
    s_valid = 1'b0;
    run_frame(32, st[3]);
    tick(1'b1);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_drained: got %b expected 1", s_ready); end
    checks++; if (xfer_seen - x0 !== 4) begin errors++; $display("FAIL bp_transfers: got %0d expected 4", xfer_seen - x0); end
    checks++; if (ur_seen - u0 !== 0) begin errors++; $display("FAIL bp_underrun: got %0d expected 0", ur_seen - u0); end
    for (int f = 0; f < 4; f++) begin
      checks++; if (word_at(st[f] + 1, 32) !== 32'h1357_9BDF) begin errors++; $display("FAIL bp_left frame %0d: got %h expected 13579bdf", f, word_at(st[f] + 1, 32)); end
      checks++; if (word_at(st[f] + 33, 32) !== 32'h2468_ACE0) begin errors++; $display("FAIL bp_right frame %0d: got %h expected 2468ace0", f, word_at(st[f] + 33, 32)); end
    end
  endtask

  task automatic test_collision();
    int st;
    int st2;
    int u0;
    int x0;
    u0 = ur_seen;
    x0 = xfer_seen;
    st = ncap;
    tick(1'b0);
    // The left load lands on the third clk edge after this fall; valid covers only that edge
    AUD_BCLK = 1'b0;
    AUD_DACLRCK = 1'b0;
    #20;
    s_left = 32'hCAFE_0123;
    s_right = 32'h0F1E_2D3C;
    s_valid = 1'b1;
    #10;
    s_valid = 1'b0;
    #10;
    AUD_BCLK = 1'b1;
    cap[ncap] = AUD_DACDAT;
    ncap++;
    #40;
    for (int i = 0; i < 30; i++) tick(1'b0);
    for (int i = 0; i < 32; i++) tick(1'b1);
    checks++; if (ur_seen - u0 !== 1) begin errors++; $display("FAIL coll_underrun: got %0d expected 1", ur_seen - u0); end
    checks++; if (xfer_seen - x0 !== 1) begin errors++; $display("FAIL coll_transfer: got %0d expected 1", xfer_seen - x0); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL coll_buffered: s_ready got %b expected 0", s_ready); end
    u0 = ur_seen;
    run_frame(32, st2);
    tick(1'b1);
    checks++; if (word_at(st + 1, 32) !== 32'h0) begin errors++; $display("FAIL coll_left_zero: got %h expected 0", word_at(st + 1, 32)); end
    checks++; if (word_at(st + 33, 32) !== 32'h0) begin errors++; $display("FAIL coll_right_zero: got %h expected 0", word_at(st + 33, 32)); end
    checks++; if (ur_seen - u0 !== 0) begin errors++; $display("FAIL coll_next_underrun: got %0d expected 0", ur_seen - u0); end
    checks++; if (word_at(st2 + 1, 32) !== 32'hCAFE_0123) begin errors++; $display("FAIL coll_next_left: got %h expected cafe0123", word_at(st2 + 1, 32)); end
    checks++; if (word_at(st2 + 33, 32) !== 32'h0F1E_2D3C) begin errors++; $display("FAIL coll_next_right: got %h expected 0f1e2d3c", word_at(st2 + 33, 32)); end
`ifdef I2S_TX_UNDERRUN_CNT_EN
    checks++; if (underrun_count !== 16'd4) begin errors++; $display("FAIL coll_count: got %0d expected 4", underrun_count); end
`endif
  endtask

  task automatic test_short_frame();
    int st1;
    int st2;
    int u0;
    u0 = ur_seen;
    push(32'h1234_5678, 32'h9ABC_DEF0);
    run_frame(16, st1);
    push(32'h0F0F_AAAA, 32'hC3C3_5555);
    run_frame(16, st2);
    tick(1'b1);
    checks++; if (word_at(st1 + 1, 16) !== 32'h1234) begin errors++; $display("FAIL short_left1: got %h expected 1234", word_at(st1 + 1, 16)); end
    checks++; if (word_at(st1 + 17, 16) !== 32'h9ABC) begin errors++; $display("FAIL short_right1: got %h expected 9abc", word_at(st1 + 17, 16)); end
    checks++; if (word_at(st2 + 1, 16) !== 32'h0F0F) begin errors++; $display("FAIL short_left2: got %h expected 0f0f", word_at(st2 + 1, 16)); end
    checks++; if (word_at(st2 + 17, 16) !== 32'hC3C3) begin errors++; $display("FAIL short_right2: got %h expected c3c3", word_at(st2 + 17, 16)); end
    checks++; if (ur_seen - u0 !== 0) begin errors++; $display("FAIL short_underrun: got %0d expected 0", ur_seen - u0); end
  endtask

  task automatic test_reset_midframe();
    int st;
    int st2;
    int st3;
    int u0;
    int ones;
    push(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    st = ncap;
    for (int i = 0; i < 11; i++) tick(1'b0);
    checks++; if (cap[st + 10] !== 1'b1) begin errors++; $display("FAIL rst_pre_bit: got %b expected 1", cap[st + 10]); end
    reset = 1'b1;
    #10;
    checks++; if (AUD_DACDAT !== 1'b0) begin errors++; $display("FAIL rst_dacdat: got %b expected 0", AUD_DACDAT); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b expected 0", s_ready); end
`ifdef I2S_TX_UNDERRUN_CNT_EN
    checks++; if (underrun_count !== 16'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", underrun_count); end
`endif
    #30;
    tick(1'b0);
    tick(1'b0);
    reset = 1'b0;
    for (int i = 0; i < 19; i++) tick(1'b0);
    for (int i = 0; i < 32; i++) tick(1'b1);
    u0 = ur_seen;
    run_frame(32, st2);
    tick(1'b1);
    checks++; if (ur_seen - u0 !== 1) begin errors++; $display("FAIL rst_discard_underrun: got %0d expected 1", ur_seen - u0); end
    ones = 0;
    for (int i = st + 11; i < ncap; i++) if (cap[i] !== 1'b0) ones++;
    checks++; if (ones !== 0) begin errors++; $display("FAIL rst_zero_output: got %0d nonzero bits expected 0", ones); end
`ifdef I2S_TX_UNDERRUN_CNT_EN
    checks++; if (underrun_count !== 16'd1) begin errors++; $display("FAIL rst_count_after: got %0d expected 1", underrun_count); end
`endif
    push(32'hDEAD_BEEF, 32'h0BAD_F00D);
    run_frame(32, st3);
    tick(1'b1);
    checks++; if (word_at(st3 + 1, 32) !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rst_resume_left: got %h expected deadbeef", word_at(st3 + 1, 32)); end
    checks++; if (word_at(st3 + 33, 32) !== 32'h0BAD_F00D) begin errors++; $display("FAIL rst_resume_right: got %h expected 0badf00d", word_at(st3 + 33, 32)); end
  endtask

  initial begin
    #7;
    test_reset();
    test_underrun();
    test_basic();
    test_back_to_back();
    test_collision();
    test_short_frame();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
